// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the M stage and the data memory.
// master = pipeline side (issues requests), slave = memory side.
interface mem_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// M-to-W pipeline stage with a blocking data-memory port.
// A load/store stalls the upstream pipe, issues one word-aligned request,
// waits for the ack (or gives up after 256 cycles and flags mem_err),
// then hands the result to the W stage on the cycle after completion.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mGPR,
    mem_stage_if.master dm,
    output logic        mem_stall,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wGPR,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wcnt;
    logic [31:0] buffer;
    logic        mem_op;
    logic        timeout;

    assign mem_op  = mm2reg | mwmem;
    assign timeout = (wcnt == 8'hFF) && !dm.dm_ack;

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and stall: stall covers the issue cycle and every wait cycle.
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                mem_stall = mem_op;
                if (mem_op) state_d = REQ;
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dm.dm_ack || timeout) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request bus, read buffer, timeout counter and W-stage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt        <= 8'd0;
            buffer      <= 32'd0;
            mem_err     <= 1'b0;
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= 32'd0;
            dm.dm_wdata <= 32'd0;
            wwreg       <= 1'b0;
            wm2reg      <= 1'b0;
            wmo         <= 32'd0;
            walu        <= 32'd0;
            wGPR        <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        // Store wins when both controls are set; address forced to a word.
                        dm.dm_req   <= 1'b1;
                        dm.dm_we    <= mwmem;
                        dm.dm_addr  <= malu & ~32'h3;
                        dm.dm_wdata <= mb;
                        wcnt        <= 8'd0;
                        wwreg       <= 1'b0;
                        wm2reg      <= 1'b0;
                        wmo         <= 32'd0;
                        walu        <= 32'd0;
                        wGPR        <= 5'd0;
                    end else begin
                        wwreg  <= mwreg;
                        wm2reg <= mm2reg;
                        wmo    <= 32'd0;
                        walu   <= malu;
                        wGPR   <= mGPR;
                    end
                end
                REQ: begin
                    wwreg  <= 1'b0;
                    wm2reg <= 1'b0;
                    wmo    <= 32'd0;
                    walu   <= 32'd0;
                    wGPR   <= 5'd0;
                    if (dm.dm_ack) begin
                        dm.dm_req <= 1'b0;
                        dm.dm_we  <= 1'b0;
                        buffer    <= dm.dm_we ? 32'd0 : dm.dm_rdata;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                        if (timeout) begin
                            dm.dm_req <= 1'b0;
                            buffer    <= 32'hDEADBEEF;
                            mem_err   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    wwreg  <= mwreg;
                    wm2reg <= mm2reg;
                    wmo    <= buffer;
                    walu   <= malu;
                    wGPR   <= mGPR;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-operation model predicts stall, request
// bus and W outputs for every cycle; literal checks pin the headline cases.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mwreg = 1'b0, mm2reg = 1'b0, mwmem = 1'b0;
    logic [31:0] malu = 32'd0, mb = 32'd0;
    logic [4:0]  mGPR = 5'd0;
    logic        mem_stall, wwreg, wm2reg, mem_err;
    logic [31:0] wmo, walu;
    logic [4:0]  wGPR;

    mem_stage_if dm_bus();

    mem_stage dut (
        .clk(clk), .rst(rst),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mGPR(mGPR),
        .dm(dm_bus),
        .mem_stall(mem_stall),
        .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wGPR(wGPR),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] mo;
        logic [31:0] alu;
        logic [4:0]  gpr;
    } wset_t;

    // Model expectations for the current cycle.
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0;
    wset_t       exp_w  = '0;
    wset_t       pend_w = '0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        chk("mem_stall", {31'd0, mem_stall}, {31'd0, exp_stall});
        chk("dm_req",    {31'd0, dm_bus.dm_req}, {31'd0, exp_req});
        chk("dm_addr_lsb", {30'd0, dm_bus.dm_addr[1:0]}, 32'd0);
        if (exp_req) begin
            chk("dm_we",    {31'd0, dm_bus.dm_we}, {31'd0, exp_we});
            chk("dm_addr",  dm_bus.dm_addr, exp_addr);
            chk("dm_wdata", dm_bus.dm_wdata, exp_wdata);
        end
        chk("wwreg",   {31'd0, wwreg},  {31'd0, exp_w.wreg});
        chk("wm2reg",  {31'd0, wm2reg}, {31'd0, exp_w.m2reg});
        chk("wmo",     wmo,  exp_w.mo);
        chk("walu",    walu, exp_w.alu);
        chk("wGPR",    {27'd0, wGPR}, {27'd0, exp_w.gpr});
        chk("mem_err", {31'd0, mem_err}, {31'd0, exp_err});
    end

    // One M-stage operation. d = REQ cycles before ack (0 = immediate); d>=256 never acks.
    task automatic run_op(input logic wr, input logic m2r, input logic wm,
                          input logic [31:0] alu, input logic [31:0] b, input logic [4:0] gpr,
                          input int d, input logic [31:0] rdata, input logic spur,
                          output int stalls, output logic [31:0] seen_addr);
        logic        memop;
        int          nreq, len;
        logic [31:0] res;
        memop = m2r | wm;
        nreq  = (d < 256) ? d + 1 : 256;
        len   = memop ? nreq + 2 : 1;
        res   = !memop ? 32'd0 : (d >= 256) ? 32'hDEADBEEF : wm ? 32'd0 : rdata;
        stalls    = 0;
        seen_addr = 32'd0;
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                mwreg = wr; mm2reg = m2r; mwmem = wm; malu = alu; mb = b; mGPR = gpr;
                exp_w = pend_w;
            end else begin
                exp_w = '0;
            end
            if (memop) begin
                // Ack on the chosen REQ cycle, plus a stray one in DONE that must be ignored.
                dm_bus.dm_ack   = (k == d + 1) || (k == nreq + 1);
                dm_bus.dm_rdata = (k == d + 1) ? rdata : $urandom;
            end else begin
                dm_bus.dm_ack   = spur;
                dm_bus.dm_rdata = $urandom;
            end
            exp_stall = memop && (k <= nreq);
            exp_req   = memop && (k >= 1) && (k <= nreq);
            exp_we    = wm;
            exp_addr  = alu & 32'hFFFF_FFFC;
            exp_wdata = b;
            if (memop && d >= 256 && k == nreq + 1) exp_err = 1'b1;
            @(negedge clk); #1;
            if (mem_stall) stalls++;
            if (k == 1) seen_addr = dm_bus.dm_addr;
        end
        dm_bus.dm_ack = 1'b0;
        pend_w = '{wreg: wr, m2reg: m2r, mo: res, alu: alu, gpr: gpr};
    endtask

    task automatic nop;
        int          s;
        logic [31:0] a;
        run_op(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 0, 32'd0, 1'b0, s, a);
    endtask

    initial begin
        int          s;
        logic [31:0] a;
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = 32'd0;

        // Held in reset for two cycles, outputs all zero.
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;

        // ALU op passes straight through.
        run_op(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'd0, 5'd3, 0, 32'd0, 1'b0, s, a);
        chk("alu_stall_cycles", s, 0);
        nop();
        chk("alu_walu", walu, 32'h10);
        chk("alu_wGPR", {27'd0, wGPR}, 32'd3);
        chk("alu_wwreg", {31'd0, wwreg}, 32'd1);

        // Load with immediate ack.
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0107, 32'd0, 5'd9, 0, 32'hCAFEF00D, 1'b0, s, a);
        chk("load_addr", a, 32'h104);
        chk("load_stall_cycles", s, 2);
        nop();
        chk("load_wmo", wmo, 32'hCAFEF00D);
        chk("load_wm2reg", {31'd0, wm2reg}, 32'd1);

        // Store with ack three cycles late.
        run_op(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h12345678, 5'd0, 3, 32'hFFFF_FFFF, 1'b0, s, a);
        chk("store_stall_cycles", s, 5);
        nop();
        chk("store_wmo", wmo, 32'd0);
        chk("store_wwreg", {31'd0, wwreg}, 32'd0);

        // Spurious ack while idle on an ALU op.
        run_op(1'b1, 1'b0, 1'b0, 32'h0000_ABCD, 32'd0, 5'd7, 0, 32'd0, 1'b1, s, a);
        chk("spur_stall_cycles", s, 0);
        nop();
        chk("spur_walu", walu, 32'hABCD);

        // Back-to-back: load then store-with-load-flag (store wins).
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0203, 32'd0, 5'd12, 1, 32'h0BAD_F00D, 1'b0, s, a);
        run_op(1'b1, 1'b1, 1'b1, 32'h0000_0302, 32'hA5A5_5A5A, 5'd13, 0, 32'h7777_7777, 1'b0, s, a);
        chk("both_store_addr", a, 32'h300);
        nop();
        chk("both_store_wmo", wmo, 32'd0);

        // Timeout: load never acked.
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'd0, 5'd4, 999, 32'd0, 1'b0, s, a);
        chk("timeout_stall_cycles", s, 257);
        nop();
        chk("timeout_wmo", wmo, 32'hDEADBEEF);
        chk("timeout_err", {31'd0, mem_err}, 32'd1);
        run_op(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'd0, 5'd5, 0, 32'd0, 1'b0, s, a);
        nop();
        chk("post_timeout_walu", walu, 32'h55);
        chk("post_timeout_err", {31'd0, mem_err}, 32'd1);

        // Reset in the middle of a REQ.
        @(posedge clk); #1;
        mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h40; mb = 32'd0; mGPR = 5'd6;
        exp_w = pend_w; exp_stall = 1'b1; exp_req = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        exp_w = '0; exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h40;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_req = 1'b0; exp_err = 1'b0; exp_stall = 1'b1; exp_w = '0;
        @(negedge clk);
        @(posedge clk); #1;
        mwreg = 1'b0; mm2reg = 1'b0; mGPR = 5'd0; malu = 32'd0;
        exp_stall = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        pend_w = '0;
        @(negedge clk);
        chk("rst_err_clear", {31'd0, mem_err}, 32'd0);

        // Normal load after reset, no retry of the abandoned one.
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0888, 32'd0, 5'd17, 2, 32'h1357_9BDF, 1'b0, s, a);
        chk("post_rst_addr", a, 32'h888);
        nop();
        chk("post_rst_wmo", wmo, 32'h1357_9BDF);
        nop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
